// File: rtl/mux_sel_arbiter.sv
// Round-robin arbiter driving the select of a shared 5-input colour mux.
// Define ARB_PRIO0_EN to make source 0 a fixed-priority source.
//
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   en           arbiter enable; low idles the arbiter at the next edge
//   req[4:0]     level request per source
//   sel[2:0]     registered mux select, 3'b111 (blank) when idle
//   grant[4:0]   registered one-hot grant, zero when idle
//   busy         high while a grant is active
//   switch       one-cycle pulse on the first cycle of each new grant
module mux_sel_arbiter #(
    parameter int BURST_LEN = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic [4:0] req,
    output logic [2:0] sel,
    output logic [4:0] grant,
    output logic       busy,
    output logic       switch
);

    localparam int CW = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
    localparam logic [CW-1:0] CMAX = CW'(BURST_LEN - 1);

    typedef enum logic {
        S_IDLE,
        S_GRANT
    } state_t;

    state_t        state_q, state_d;
    logic [2:0]    cur_q, cur_d;
    logic [2:0]    last_q, last_d;
    logic [2:0]    sel_q, sel_d;
    logic [4:0]    grant_q, grant_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          sw_q, sw_d;

    logic          win_vld;
    logic [2:0]    win_idx;
    logic          keep_ptr;
    logic          rel;

    // Scan from last+5 down to last+1 so the nearest requester after
    // the pointer is the final (winning) assignment.
    always_comb begin
        int j;
        logic [2:0] idx;
        win_vld  = 1'b0;
        win_idx  = 3'd0;
        keep_ptr = 1'b0;
        j        = 0;
        idx      = 3'd0;
        for (int i = 5; i >= 1; i--) begin
            j = int'(last_q) + i;
            if (j >= 5) j = j - 5;
            idx = 3'(j);
            if (req[idx]) begin
                win_vld = 1'b1;
                win_idx = idx;
            end
        end
`ifdef ARB_PRIO0_EN
        // Overlay source pre-empts the rotation and leaves the pointer alone.
        if (req[0]) begin
            win_vld  = 1'b1;
            win_idx  = 3'd0;
            keep_ptr = 1'b1;
        end
`endif
    end

    always_comb begin
        state_d = state_q;
        cur_d   = cur_q;
        last_d  = last_q;
        cnt_d   = cnt_q;
        sel_d   = sel_q;
        grant_d = grant_q;
        sw_d    = 1'b0;
        rel     = 1'b1;
        if (!en) begin
            state_d = S_IDLE;
            sel_d   = 3'b111;
            grant_d = 5'b0;
            cnt_d   = '0;
        end else begin
            case (state_q)
                S_IDLE:  rel = 1'b1;
                S_GRANT: rel = !req[cur_q] || (cnt_q == CMAX);
                default: rel = 1'b1;
            endcase
            if (!rel) begin
                cnt_d = cnt_q + CW'(1);
            end else if (win_vld) begin
                // Hand-over happens in the same edge, even to the same source.
                state_d = S_GRANT;
                cur_d   = win_idx;
                if (!keep_ptr) last_d = win_idx;
                cnt_d   = '0;
                sel_d   = win_idx;
                grant_d = 5'(5'b1 << win_idx);
                sw_d    = 1'b1;
            end else begin
                state_d = S_IDLE;
                sel_d   = 3'b111;
                grant_d = 5'b0;
                cnt_d   = '0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cur_q   <= 3'd0;
            last_q  <= 3'd4;
            cnt_q   <= '0;
            sel_q   <= 3'b111;
            grant_q <= 5'b0;
            sw_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cur_q   <= cur_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
            sel_q   <= sel_d;
            grant_q <= grant_d;
            sw_q    <= sw_d;
        end
    end

    assign sel    = sel_q;
    assign grant  = grant_q;
    assign busy   = (state_q == S_GRANT);
    assign switch = sw_q;

endmodule
